// File: rtl/traffic_phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer_if
//   Groups the sequencer's control inputs and lamp/handshake outputs into one
//   bundle. The module that supplies stimulus uses the master view. The
//   sequencer itself uses the slave view.
//
//   sec_level  1 Hz toggling level from the divider; a rising edge is one tick
//   hold       1 = freeze the sequence (ticks discarded)
//   car_ew     EW car-demand sensor (level)
//   ped_req    pedestrian request pulse (>= 1 cycle)
//   ns_light   NS lamps {red,yellow,green}, one-hot
//   ew_light   EW lamps {red,yellow,green}, one-hot
//   walk       pedestrian walk lamp
//   ped_ack    one-cycle pulse: a pedestrian request was latched
//   phase      current state encoding
// -----------------------------------------------------------------------------
interface traffic_phase_sequencer_if;
  logic       sec_level;
  logic       hold;
  logic       car_ew;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output sec_level, hold, car_ew, ped_req,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  sec_level, hold, car_ew, ped_req,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//   Steps a two-road intersection through its light phases, one step per 1 s
//   tick. A tick is a rising edge of the divider's toggling sec_level.
//   The normal order is:
//     RED_A -> NS_G -> NS_Y -> RED_B -> EW_G -> EW_Y -> RED_A
//   Each phase lasts its T_* ticks.
//   NS green is extended in whole green periods, at most MAX_EXT times in a
//   row, while there is no EW demand and no pedestrian waiting.
//
//   Ports:
//     clock  system clock
//     reset  asynchronous, active-high reset
//     bus    traffic_phase_sequencer_if.slave. Inputs are sec_level, hold,
//            car_ew and ped_req. Outputs are ns_light, ew_light, walk,
//            ped_ack and phase.
//
//   Optional feature, macro PED_WALK_EN:
//     Defined: a latched pedestrian request diverts RED_A into a WALK phase.
//     Undefined: ped_req is ignored, and walk and ped_ack stay 0.
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int unsigned T_GREEN  = 10,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 5,
  parameter int unsigned MAX_EXT  = 3,
  parameter int unsigned CW       = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  traffic_phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    RED_A = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    RED_B = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    WALK  = 3'd6,
    BAD   = 3'd7
  } state_e;

  localparam int unsigned EXT_W = (MAX_EXT < 2) ? 1 : $clog2(MAX_EXT + 1);
  localparam logic [EXT_W-1:0] MAX_EXT_V = EXT_W'(MAX_EXT);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EXT_W-1:0] ext_cnt_q, ext_cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_ack_q, ped_ack_d;
  logic             sec_q, sec_d;
  logic             tick;

  // Counter reload value on entry to a state (phase length minus one).
  function automatic logic [CW-1:0] load_for(state_e s);
    case (s)
      NS_G, EW_G: load_for = CW'(T_GREEN - 1);
      NS_Y, EW_Y: load_for = CW'(T_YELLOW - 1);
      WALK:       load_for = CW'(T_WALK - 1);
      default:    load_for = CW'(T_ALLRED - 1);
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so that no path leaves one
    // unassigned. An unassigned path would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    ext_cnt_d     = ext_cnt_q;
    ped_pending_d = 1'b0;
    ped_ack_d     = 1'b0;
    sec_d         = bus.sec_level;
    tick          = bus.sec_level & ~sec_q;

`ifdef PED_WALK_EN
    ped_pending_d = ped_pending_q;
    // A request is taken only when none is pending and no walk is running.
    // It is latched even while the sequence is on hold.
    if (bus.ped_req && !ped_pending_q && (state_q != WALK)) begin
      ped_pending_d = 1'b1;
      ped_ack_d     = 1'b1;
    end
`endif

    if (state_q == BAD) begin
      // The unused code recovers on the next clock, tick or not.
      state_d   = RED_A;
      cnt_d     = load_for(RED_A);
      ext_cnt_d = '0;
    end else if (tick && !bus.hold) begin
      // The zero test comes before the decrement, so the counter never wraps.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        case (state_q)
          RED_A: state_d = ped_pending_q ? WALK : NS_G;
          NS_G: begin
            if (!bus.car_ew && !ped_pending_q && (ext_cnt_q < MAX_EXT_V))
              ext_cnt_d = ext_cnt_q + EXT_W'(1);
            else
              state_d = NS_Y;
          end
          NS_Y:    state_d = RED_B;
          RED_B:   state_d = EW_G;
          EW_G:    state_d = EW_Y;
          EW_Y:    state_d = RED_A;
          WALK:    state_d = NS_G;
          default: state_d = RED_A;
        endcase
        // An extension also reloads, giving another full green period.
        cnt_d = load_for(state_d);
        if (state_d != NS_G) ext_cnt_d = '0;
`ifdef PED_WALK_EN
        if (state_d == WALK) ped_pending_d = 1'b0;
`endif
      end
    end
  end

  // sec_q resets high, so a level that is already high at reset release is
  // not counted as a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RED_A;
      cnt_q         <= CW'(T_ALLRED - 1);
      ext_cnt_q     <= '0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
      sec_q         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the
      // pre-edge values. Blocking assignments here would create ordering
      // races between flops.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ext_cnt_q     <= ext_cnt_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
      sec_q         <= sec_d;
    end
  end

  // Lamp decode comes from the state register only, so both roads can never
  // be non-red at the same time.
  always_comb begin
    bus.ns_light = 3'b100;
    bus.ew_light = 3'b100;
    case (state_q)
      NS_G:    bus.ns_light = 3'b001;
      NS_Y:    bus.ns_light = 3'b010;
      EW_G:    bus.ew_light = 3'b001;
      EW_Y:    bus.ew_light = 3'b010;
      default: ;
    endcase
  end

  assign bus.phase   = state_q;
  assign bus.ped_ack = ped_ack_q;

`ifdef PED_WALK_EN
  assign bus.walk = (state_q == WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign bus.walk       = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//   Directed stimulus for traffic_phase_sequencer.
//   A phase-level model counts elapsed ticks per phase against a duration
//   table. A negedge compare process checks every output against that model.
//   Literal phase durations pin the model itself.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;
  localparam int T_GREEN  = 10;
  localparam int T_YELLOW = 3;
  localparam int T_ALLRED = 1;
  localparam int T_WALK   = 5;
  localparam int MAX_EXT  = 3;
`ifdef PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  traffic_phase_sequencer_if bus();

  traffic_phase_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #100 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- phase-level model ----------------
  function automatic int dur_of(input int p);
    case (p)
      1, 4:    return T_GREEN;
      2, 5:    return T_YELLOW;
      6:       return T_WALK;
      default: return T_ALLRED;
    endcase
  endfunction

  function automatic int ns_exp(input int p);
    return (p == 1) ? 1 : (p == 2) ? 2 : 4;
  endfunction

  function automatic int ew_exp(input int p);
    return (p == 4) ? 1 : (p == 5) ? 2 : 4;
  endfunction

  int m_phase, m_elapsed, m_ext;
  bit m_pend, m_ack, m_prev_sec;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase    <= 0;
      m_elapsed  <= 0;
      m_ext      <= 0;
      m_pend     <= 1'b0;
      m_ack      <= 1'b0;
      m_prev_sec <= 1'b1;
    end else begin : step
      int ph, el, ex;
      bit pd, ak, tk;
      ph = m_phase; el = m_elapsed; ex = m_ext; pd = m_pend; ak = 1'b0;
      tk = bus.sec_level && !m_prev_sec;
      if (PED_EN && bus.ped_req && !m_pend && m_phase != 6) begin
        pd = 1'b1; ak = 1'b1;
      end
      if (tk && !bus.hold) begin
        if (m_elapsed < dur_of(m_phase) - 1) el = m_elapsed + 1;
        else begin
          el = 0;
          case (m_phase)
            0: ph = m_pend ? 6 : 1;
            1: if (!bus.car_ew && !m_pend && m_ext < MAX_EXT) ex = m_ext + 1;
               else begin ph = 2; ex = 0; end
            6: ph = 1;
            default: ph = (m_phase + 1) % 6;
          endcase
          if (ph == 6) pd = 1'b0;
        end
      end
      m_phase    <= ph;
      m_elapsed  <= el;
      m_ext      <= ex;
      m_pend     <= pd;
      m_ack      <= ak;
      m_prev_sec <= bus.sec_level;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("phase",    int'(bus.phase),    m_phase);
      check("ns_light", int'(bus.ns_light), ns_exp(m_phase));
      check("ew_light", int'(bus.ew_light), ew_exp(m_phase));
      check("walk",     int'(bus.walk),     (m_phase == 6) ? 1 : 0);
      check("ped_ack",  int'(bus.ped_ack),  int'(m_ack));
      check("one_road_red",
            (bus.ns_light != 3'b100 && bus.ew_light != 3'b100) ? 1 : 0, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Each helper starts and ends 20 time units after a posedge.
  task automatic do_tick();
    bus.sec_level = 1'b0;
    @(posedge clock); #20;
    bus.sec_level = 1'b1;
    @(posedge clock); #20;
    @(posedge clock); #20;
  endtask

  task automatic run_until_change(output int n);
    int start;
    start = int'(bus.phase);
    n = 0;
    while (int'(bus.phase) == start && n < 200) begin
      do_tick();
      n++;
    end
  endtask

  task automatic run_to_phase(input int p);
    int k;
    k = 0;
    while (int'(bus.phase) != p && k < 100) begin
      do_tick();
      k++;
    end
    check("run_to_phase", int'(bus.phase), p);
  endtask

  task automatic pulse_ped();
    bus.ped_req = 1'b1;
    @(posedge clock); #20;
    bus.ped_req = 1'b0;
  endtask

  int exp1 [6] = '{1, 10, 3, 1, 10, 3};

  initial begin
    int n;
    bus.sec_level = 1'b0;
    bus.hold      = 1'b0;
    bus.car_ew    = 1'b1;
    bus.ped_req   = 1'b0;
    reset         = 1'b1;
    #1;
    check("rst_phase", int'(bus.phase),    0);
    check("rst_ns",    int'(bus.ns_light), 4);
    check("rst_ew",    int'(bus.ew_light), 4);
    check("rst_walk",  int'(bus.walk),     0);
    check("rst_ack",   int'(bus.ped_ack),  0);
    repeat (3) @(posedge clock);
    #20 reset = 1'b0;
    @(posedge clock); #20;

    // Full cycle with EW demand present: no extensions.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_start_ph%0d", i), int'(bus.phase), i);
      run_until_change(n);
      check($sformatf("t1_dur_ph%0d", i), n, exp1[i]);
    end
    check("t1_back_to_red_a", int'(bus.phase), 0);

    // No EW demand: NS green is extended three times (4 x 10 ticks).
    bus.car_ew = 1'b0;
    run_until_change(n);
    check("t2_red_a_dur", n, 1);
    run_until_change(n);
    check("t2_ns_g_dur", n, 40);
    check("t2_next_ns_y", int'(bus.phase), 2);
    bus.car_ew = 1'b1;

    // Pedestrian request during EW green.
    run_to_phase(4);
    pulse_ped();
    check("t3_ack_after_req", int'(bus.ped_ack), PED_EN ? 1 : 0);
    run_to_phase(0);
    run_until_change(n);
    check("t3_red_a_dur", n, 1);
    check("t3_after_red_a", int'(bus.phase), PED_EN ? 6 : 1);
    check("t3_walk_lamp",   int'(bus.walk),  PED_EN ? 1 : 0);
    check("t3_ns_red",      int'(bus.ns_light), PED_EN ? 4 : 1);
    check("t3_ew_red",      int'(bus.ew_light), 4);
    do_tick();
    do_tick();
    pulse_ped();
    check("t3_no_ack_in_walk", int'(bus.ped_ack), 0);
    run_until_change(n);
    check("t3_rest_dur", n, PED_EN ? 3 : 8);
    check("t3_next",     int'(bus.phase), PED_EN ? 1 : 2);

    // Hold at NS green with the counter at 4.
    run_to_phase(1);
    repeat (5) do_tick();
    bus.hold = 1'b1;
    repeat (20) do_tick();
    check("t4_held_phase", int'(bus.phase), 1);
    bus.hold = 1'b0;
    run_until_change(n);
    check("t4_rest_dur", n, 5);
    check("t4_next", int'(bus.phase), 2);

    // Reset in the middle of EW green. sec_level is still high at release,
    // so that level must not count as a tick.
    run_to_phase(4);
    do_tick();
    do_tick();
    check("t5_pre_phase", int'(bus.phase), 4);
    @(posedge clock); #50;
    reset = 1'b1;
    #1;
    check("t5_ns_100", int'(bus.ns_light), 4);
    check("t5_ew_100", int'(bus.ew_light), 4);
    check("t5_phase0", int'(bus.phase),    0);
    repeat (2) @(posedge clock);
    #20 reset = 1'b0;
    repeat (4) @(posedge clock);
    #20;
    check("t6_no_tick_at_release", int'(bus.phase), 0);
    run_until_change(n);
    check("t5_red_a_dur", n, 1);
    check("t5_next", int'(bus.phase), 1);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
